fmul_wb_queue: RTL and testbench
================================

// Module: fmul_wb_queue
// PURPOSE
// - Sits directly downstream of the 3-stage pipelined FP multiplier and upstream of the FPU register-file writeback.
// - Carries each issued op's destination tag through a shadow pipeline matched to the multiplier latency.
// - Pairs that tag with the returning product and buffers results in a credit-protected FIFO.
// - Drains the FIFO to writeback with a valid/ready handshake, and keeps sticky overflow/underflow flags.
// PARAMETERS
// - LATENCY   3   multiplier cycles, from issue (stage1_valid) to out_valid
// - DEPTH     4   result FIFO entries; power of 2; must be >= LATENCY+1
// - TAG_W     5   destination register tag width
// PORTS
// - sys_clk       in   1      clock
// - rstn          in   1      reset, asynchronous, active-low
// - issue_valid   in   1      op issued to fmul this cycle; same cycle as fmul stage1_valid
// - issue_tag     in   TAG_W  destination register of the issued op
// - issue_ready   out  1      credit available; issuer must not assert issue_valid while low
// - mul_valid     in   1      fmul out_valid
// - mul_y         in   32     fmul y
// - mul_ovf       in   1      fmul ovf
// - mul_unf       in   1      fmul unf
// - wb_valid      out  1      FIFO head valid
// - wb_ready      in   1      writeback accepts head
// - wb_tag        out  TAG_W  head destination tag
// - wb_data       out  32     head result
// - wb_exc        out  2      head {ovf,unf}
// - flags_clr     in   1      clear sticky flags
// - flag_ovf      out  1      sticky OR of ovf over accepted results
// - flag_unf      out  1      sticky OR of unf over accepted results
// - err           out  1      sticky protocol error
// BEHAVIOUR
// - Reset: all valids, counters, pointers, flags and err are 0. wb_tag/wb_data/wb_exc are 0.
// - issue_ready is 1 after reset release.
// - Shadow pipe: LATENCY-deep {v,tag} shift register, loaded with {issue_valid & issue_ready, issue_tag}.
//   - A tag emerges on the cycle the matching mul_valid arrives (3 edges after issue).
// - Capture: mul_valid with pipe-out v=1 pushes {tag, mul_y, mul_ovf, mul_unf} into the FIFO.
//   - mul_valid != pipe-out v sets err. A lone mul_valid is dropped; a lone tag is discarded.
// - issue_valid while issue_ready=0 sets err, and the op is not tracked.
// - Credit: inflight = popcount of shadow v bits; count = FIFO occupancy.
//   - issue_ready = (count + inflight) < DEPTH, computed combinationally from registered state.
//   - With DEPTH >= LATENCY+1 a push never meets a full FIFO. If it does (broken issuer), drop the push and set err.
// - Pop: wb_valid & wb_ready. Push and pop in the same cycle leave count unchanged; legal at any occupancy, including full and empty.
// - Pointers: log2(DEPTH) bits, natural wrap; count is log2(DEPTH)+1 bits.
// - Head: wb_* driven from registered FIFO storage at rptr; wb_valid = (count != 0).
//   - wb_* are held stable while wb_valid & ~wb_ready.
//   - Zero-latency bypass is not allowed: minimum latency is 1 cycle from mul_valid to wb_valid.
// - Flags: set on pop (not on push) from head exc bits.
//   - flags_clr clears them. If flags_clr coincides with a pop, the pop's bits win, so no exception is lost.
// - err is cleared only by reset.
// - Reset mid-operation: in-flight tags and queued results are discarded. Upstream fmul valids are reset in the same domain.
// STRUCTURE
// - fpu_pkg: typedef struct packed {logic [TAG_W-1:0] tag; logic [31:0] data; logic ovf, unf;} fpu_wb_t;
//   plus localparams FMUL_LATENCY=3 and FPU_TAG_W=5, shared with the adder/divider writeback queues.
// - One sub-module: fpu_sync_fifo (width-generic, push/pop/count/full/empty, async active-low reset).
//   Reused by the other FPU units.
// - Top level holds the shadow pipe, credit logic, capture checks and flags (about 200 lines total).
// TESTING
// - Single op: issue tag=7 at t0; mul_valid with y=0x40C00000 at t0+3 -> wb_valid at t0+4, wb_tag=7, wb_data=0x40C00000.
// - Back-to-back: 4 issues on consecutive cycles, wb_ready=0 -> issue_ready drops after the 4th issue.
//   - FIFO holds 4 entries in order; release wb_ready -> tags drain in issue order, one per cycle.
// - Simultaneous push/pop: with count=2, a mul_valid arrives while wb_ready=1 -> count stays 2, ordering is preserved.
// - Flags: a result with ovf=1 is popped -> flag_ovf=1.
//   - flags_clr on the same cycle as a pop with unf=1 -> flag_ovf=0, flag_unf=1.
// - Protocol: mul_valid with no tracked issue -> err=1, nothing pushed.
//   - issue_valid while issue_ready=0 -> err=1.
// - Reset mid-flight: drop rstn asynchronously with 2 in flight and 2 queued -> wb_valid=0 immediately.
//   - After release, count=0 and issue_ready=1.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU writeback definitions: unit latencies, tag width and the
// writeback record carried by the per-unit result queues.
package fpu_pkg;

  localparam int FMUL_LATENCY = 3;
  localparam int FPU_TAG_W    = 5;
  localparam int FPU_DATA_W   = 32;

  // One writeback record: destination tag, result and exception bits.
  typedef struct packed {
    logic [FPU_TAG_W-1:0]  tag;
    logic [FPU_DATA_W-1:0] data;
    logic                  ovf;
    logic                  unf;
  } fpu_wb_t;

endpackage : fpu_pkg

// File: rtl/fmul_wb_queue_if.sv
// Bundle of the issue, multiplier-return, writeback and flag signals of the
// fmul writeback queue. The queue uses the slave view; its environment
// (issuer, multiplier, writeback port) uses the master view.
interface fmul_wb_queue_if
  import fpu_pkg::*;
#(
  parameter int TAG_W = FPU_TAG_W
);

  logic             issue_valid;
  logic [TAG_W-1:0] issue_tag;
  logic             issue_ready;

  logic             mul_valid;
  logic [31:0]      mul_y;
  logic             mul_ovf;
  logic             mul_unf;

  logic             wb_valid;
  logic             wb_ready;
  logic [TAG_W-1:0] wb_tag;
  logic [31:0]      wb_data;
  logic [1:0]       wb_exc;

  logic             flags_clr;
  logic             flag_ovf;
  logic             flag_unf;
  logic             err;

  modport master (
    output issue_valid, issue_tag, mul_valid, mul_y, mul_ovf, mul_unf,
           wb_ready, flags_clr,
    input  issue_ready, wb_valid, wb_tag, wb_data, wb_exc,
           flag_ovf, flag_unf, err
  );

  modport slave (
    input  issue_valid, issue_tag, mul_valid, mul_y, mul_ovf, mul_unf,
           wb_ready, flags_clr,
    output issue_ready, wb_valid, wb_tag, wb_data, wb_exc,
           flag_ovf, flag_unf, err
  );

endinterface : fmul_wb_queue_if

// File: rtl/fpu_sync_fifo.sv
// Width-generic synchronous FIFO used by the FPU writeback queues.
// Push and pop may happen together at any occupancy; a push into a full
// FIFO is accepted only when a pop frees the slot in the same cycle.
module fpu_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     sys_clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty    = (count == '0);
  assign full     = (count == CNT_FULL);
  assign pop_ok   = pop & ~empty;
  assign push_ok  = push & (~full | pop_ok);
  assign pop_data = mem[rptr];

  // Storage write at the write pointer.
  // NOTE: the storage array has no reset; count/empty qualify every read, so
  // stale contents are never observed and the array can map to plain RAM.
  always_ff @(posedge sys_clk) begin
    if (push_ok) mem[wptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  // NOTE: all sequential state is assigned with <= so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + PTR_ONE;
      if (pop_ok)  rptr <= rptr + PTR_ONE;
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule : fpu_sync_fifo

// File: rtl/fmul_wb_queue.sv
// Writeback queue behind the pipelined FP multiplier. A shadow pipe carries
// each issued op's destination tag alongside the multiplier, the tag is
// paired with the returning product, and results are buffered in a
// credit-protected FIFO that drains to register-file writeback.
module fmul_wb_queue
  import fpu_pkg::*;
#(
  parameter int LATENCY = FMUL_LATENCY,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = FPU_TAG_W
) (
  input  logic           sys_clk,
  input  logic           rstn,
  fmul_wb_queue_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] CREDIT_LIMIT = (CW+1)'(DEPTH);

  // Same layout as fpu_wb_t, sized by this instance's tag width.
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
    logic             ovf;
    logic             unf;
  } entry_t;

  logic [LATENCY-1:0] sh_v;
  logic [TAG_W-1:0]   sh_tag [LATENCY];

  logic               issue_ok;
  logic               pipe_v;
  logic               capture;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CW-1:0]      count;
  logic [CW:0]        credit_used;
  entry_t             push_entry;
  entry_t             head;
  logic               flag_ovf_q;
  logic               flag_unf_q;
  logic               err_q;
  logic               err_set;

  assign issue_ok = bus.issue_valid & bus.issue_ready;
  assign pipe_v   = sh_v[LATENCY-1];
  assign capture  = bus.mul_valid & pipe_v;
  assign pop      = bus.wb_valid & bus.wb_ready;

  // Credit: queued results plus tags still travelling with the multiplier.
  always_comb begin
    credit_used = {1'b0, count};
    for (int i = 0; i < LATENCY; i++) begin
      credit_used = credit_used + {{CW{1'b0}}, sh_v[i]};
    end
  end

  assign bus.issue_ready = (credit_used < CREDIT_LIMIT);

  // Shadow pipe: tags advance one stage per cycle in step with the multiplier.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      sh_v <= '0;
      for (int i = 0; i < LATENCY; i++) sh_tag[i] <= '0;
    end else begin
      sh_v[0]   <= issue_ok;
      sh_tag[0] <= bus.issue_tag;
      for (int i = 1; i < LATENCY; i++) begin
        sh_v[i]   <= sh_v[i-1];
        sh_tag[i] <= sh_tag[i-1];
      end
    end
  end

  assign push_entry = '{tag:  sh_tag[LATENCY-1],
                        data: bus.mul_y,
                        ovf:  bus.mul_ovf,
                        unf:  bus.mul_unf};

  fpu_sync_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .sys_clk   (sys_clk),
    .rstn      (rstn),
    .push      (capture),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head),
    .count     (count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Writeback head: registered storage at the read pointer, zeroed when empty.
  // NOTE: every output gets a default before the conditional so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    bus.wb_valid = 1'b0;
    bus.wb_tag   = '0;
    bus.wb_data  = '0;
    bus.wb_exc   = '0;
    if (!fifo_empty) begin
      bus.wb_valid = 1'b1;
      bus.wb_tag   = head.tag;
      bus.wb_data  = head.data;
      bus.wb_exc   = {head.ovf, head.unf};
    end
  end

  // Protocol violations: issue without credit, tag/product mismatch, and a
  // capture that meets a full FIFO with no pop to make room.
  assign err_set = (bus.issue_valid & ~bus.issue_ready)
                 | (bus.mul_valid ^ pipe_v)
                 | (capture & fifo_full & ~pop);

  // Sticky flags follow popped results; a pop's bits survive a same-cycle clear.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      flag_ovf_q <= 1'b0;
      flag_unf_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      flag_ovf_q <= (flag_ovf_q & ~bus.flags_clr) | (pop & head.ovf);
      flag_unf_q <= (flag_unf_q & ~bus.flags_clr) | (pop & head.unf);
      err_q      <= err_q | err_set;
    end
  end

  assign bus.flag_ovf = flag_ovf_q;
  assign bus.flag_unf = flag_unf_q;
  assign bus.err      = err_q;

endmodule : fmul_wb_queue

// File: tb/tb_fmul_wb_queue.sv
// Self-checking bench for fmul_wb_queue: a transaction-level model (queues of
// tracked issues and queued results) predicts every output each cycle, with
// directed scenarios pinned by literal expectations and a randomized phase.
module tb_fmul_wb_queue;
  import fpu_pkg::*;

  localparam int DEPTH = 4;
  localparam int LAT   = FMUL_LATENCY;

  logic sys_clk = 1'b0;
  logic rstn    = 1'b0;

  always #5 sys_clk = ~sys_clk;

  fmul_wb_queue_if #(.TAG_W(FPU_TAG_W)) bus ();

  fmul_wb_queue #(
    .LATENCY (LAT),
    .DEPTH   (DEPTH),
    .TAG_W   (FPU_TAG_W)
  ) dut (
    .sys_clk (sys_clk),
    .rstn    (rstn),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  typedef struct {
    logic [FPU_TAG_W-1:0] tag;
    int                   due;
  } trk_t;

  trk_t    trk[$];
  fpu_wb_t fq[$];
  logic    m_ovf, m_unf, m_err;
  int      m_cyc = 0;

  // Multiplier emulation controls.
  bit          auto_mul  = 1'b1;
  bit          fix_y     = 1'b1;
  logic [31:0] fix_y_val = 32'h0;
  logic        fix_ovf   = 1'b0;
  logic        fix_unf   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, m_cyc, act, exp);
    end
  endtask

  function automatic bit m_ready();
    return (fq.size() + trk.size()) < DEPTH;
  endfunction

  function automatic bit m_pipe_v();
    return (trk.size() > 0) && (trk[0].due == m_cyc);
  endfunction

  // Compare every DUT output with the model's prediction for this cycle.
  task automatic compare_all();
    fpu_wb_t h;
    h = '0;
    if (fq.size() > 0) h = fq[0];
    check("issue_ready", bus.issue_ready, m_ready());
    check("wb_valid",    bus.wb_valid,    fq.size() != 0);
    check("wb_tag",      bus.wb_tag,      h.tag);
    check("wb_data",     bus.wb_data,     h.data);
    check("wb_exc",      bus.wb_exc,      {h.ovf, h.unf});
    check("flag_ovf",    bus.flag_ovf,    m_ovf);
    check("flag_unf",    bus.flag_unf,    m_unf);
    check("err",         bus.err,         m_err);
  endtask

  // Advance the model across one clock edge using the inputs the bench drove.
  task automatic model_edge();
    bit      rdy, pv, pop, cap;
    fpu_wb_t h, e;
    trk_t    t;
    rdy = m_ready();
    pv  = m_pipe_v();
    pop = (fq.size() > 0) && bus.wb_ready;
    cap = bus.mul_valid && pv;
    if (bus.issue_valid && !rdy) m_err = 1'b1;
    if (bus.mul_valid != pv)     m_err = 1'b1;
    if (bus.flags_clr) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    if (pop) begin
      h = fq.pop_front();
      m_ovf = m_ovf | h.ovf;
      m_unf = m_unf | h.unf;
    end
    if (cap) begin
      e.tag  = trk[0].tag;
      e.data = bus.mul_y;
      e.ovf  = bus.mul_ovf;
      e.unf  = bus.mul_unf;
      if (fq.size() >= DEPTH) m_err = 1'b1;
      else fq.push_back(e);
    end
    if (pv) trk.delete(0);
    if (bus.issue_valid && rdy) begin
      t.tag = bus.issue_tag;
      t.due = m_cyc + LAT;
      trk.push_back(t);
    end
    m_cyc++;
  endtask

  // One clock cycle: check outputs, drive the multiplier return, clock the model.
  task automatic cycle();
    compare_all();
    if (auto_mul) begin
      bus.mul_valid = m_pipe_v();
      if (m_pipe_v()) begin
        bus.mul_y   = fix_y ? fix_y_val : $urandom();
        bus.mul_ovf = fix_y ? fix_ovf : ($urandom_range(0, 7) == 0);
        bus.mul_unf = fix_y ? fix_unf : ($urandom_range(0, 7) == 0);
      end
    end
    @(posedge sys_clk);
    model_edge();
    @(negedge sys_clk);
  endtask

  task automatic idle(input int n);
    bus.issue_valid = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic issue(input logic [FPU_TAG_W-1:0] t);
    bus.issue_valid = 1'b1;
    bus.issue_tag   = t;
    cycle();
    bus.issue_valid = 1'b0;
  endtask

  task automatic clear_inputs();
    bus.issue_valid = 1'b0;
    bus.issue_tag   = '0;
    bus.mul_valid   = 1'b0;
    bus.mul_y       = '0;
    bus.mul_ovf     = 1'b0;
    bus.mul_unf     = 1'b0;
    bus.wb_ready    = 1'b0;
    bus.flags_clr   = 1'b0;
  endtask

  // Asynchronous reset asserted mid-cycle, released on a falling edge.
  task automatic do_reset();
    #2 rstn = 1'b0;
    #1 check("rst_async_wb_valid", bus.wb_valid, 1'b0);
    trk.delete();
    fq.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_err = 1'b0;
    clear_inputs();
    @(posedge sys_clk);
    @(negedge sys_clk);
    check("rst_hold_issue_ready", bus.issue_ready, 1'b1);
    check("rst_hold_err",         bus.err,         1'b0);
    rstn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_err = 1'b0;
    clear_inputs();
    repeat (2) @(negedge sys_clk);

    // Reset values.
    check("reset_issue_ready", bus.issue_ready, 1'b1);
    check("reset_wb_valid",    bus.wb_valid,    1'b0);
    check("reset_wb_tag",      bus.wb_tag,      '0);
    check("reset_wb_data",     bus.wb_data,     '0);
    check("reset_flags",       {bus.flag_ovf, bus.flag_unf}, 2'b00);
    check("reset_err",         bus.err,         1'b0);
    rstn = 1'b1;

    // Single op: tag 7, product arrives three cycles later, visible one after.
    fix_y_val = 32'h40C0_0000;
    issue(5'd7);
    idle(2);
    check("single_min_latency", bus.wb_valid, 1'b0);
    idle(1);
    check("single_wb_valid", bus.wb_valid, 1'b1);
    check("single_wb_tag",   bus.wb_tag,   5'd7);
    check("single_wb_data",  bus.wb_data,  32'h40C0_0000);
    bus.wb_ready = 1'b1;
    idle(1);
    check("single_drained", bus.wb_valid, 1'b0);

    // Back-to-back: four issues fill the credit, then drain in issue order.
    bus.wb_ready = 1'b0;
    fix_y_val    = 32'h3F80_0000;
    for (int t = 1; t <= 4; t++) issue(5'(t));
    check("b2b_ready_low", bus.issue_ready, 1'b0);
    idle(3);
    check("b2b_full_valid", bus.wb_valid,    1'b1);
    check("b2b_full_ready", bus.issue_ready, 1'b0);
    bus.wb_ready = 1'b1;
    for (int t = 1; t <= 4; t++) begin
      check("b2b_drain_order", bus.wb_tag, 5'(t));
      idle(1);
    end
    check("b2b_empty",    bus.wb_valid,    1'b0);
    check("b2b_ready_up", bus.issue_ready, 1'b1);

    // Simultaneous push and pop at count 2.
    bus.wb_ready = 1'b0;
    issue(5'd10);
    issue(5'd11);
    issue(5'd12);
    idle(2);
    check("pp_head_before", bus.wb_tag, 5'd10);
    bus.wb_ready = 1'b1;
    idle(1);
    check("pp_head_after", bus.wb_tag, 5'd11);
    idle(1);
    check("pp_second", bus.wb_tag, 5'd12);
    idle(1);
    check("pp_empty", bus.wb_valid, 1'b0);

    // Flags: ovf popped, then clear coinciding with an unf pop.
    bus.wb_ready = 1'b0;
    fix_ovf = 1'b1;
    issue(5'd3);
    idle(3);
    fix_ovf = 1'b0;
    check("flag_ovf_not_on_push", bus.flag_ovf, 1'b0);
    bus.wb_ready = 1'b1;
    idle(1);
    check("flag_ovf_set",   bus.flag_ovf, 1'b1);
    check("flag_unf_clean", bus.flag_unf, 1'b0);
    bus.wb_ready = 1'b0;
    fix_unf = 1'b1;
    issue(5'd4);
    idle(3);
    fix_unf = 1'b0;
    bus.flags_clr = 1'b1;
    bus.wb_ready  = 1'b1;
    idle(1);
    bus.flags_clr = 1'b0;
    check("clr_pop_ovf", bus.flag_ovf, 1'b0);
    check("clr_pop_unf", bus.flag_unf, 1'b1);

    // Randomized legal traffic against the model.
    fix_y = 1'b0;
    for (int c = 0; c < 400; c++) begin
      bus.issue_valid = m_ready() && ($urandom_range(0, 1) == 1);
      bus.issue_tag   = 5'($urandom());
      bus.wb_ready    = ((c % 64) < 24) ? ($urandom_range(0, 9) == 0)
                                        : ($urandom_range(0, 3) != 0);
      bus.flags_clr   = ($urandom_range(0, 15) == 0);
      cycle();
    end
    bus.flags_clr = 1'b0;
    bus.wb_ready  = 1'b1;
    idle(8);
    check("rand_drained", bus.wb_valid, 1'b0);
    fix_y = 1'b1;

    // Protocol: a multiplier result with no tracked issue.
    auto_mul      = 1'b0;
    bus.mul_valid = 1'b1;
    bus.mul_y     = 32'hDEAD_BEEF;
    idle(1);
    bus.mul_valid = 1'b0;
    auto_mul      = 1'b1;
    check("lone_mul_err",     bus.err,      1'b1);
    check("lone_mul_dropped", bus.wb_valid, 1'b0);
    do_reset();

    // Protocol: issue while credit is exhausted.
    bus.wb_ready = 1'b0;
    for (int t = 1; t <= 4; t++) issue(5'(t));
    check("nocredit_ready", bus.issue_ready, 1'b0);
    issue(5'd9);
    check("nocredit_err", bus.err, 1'b1);
    idle(4);
    check("nocredit_queue", bus.wb_valid, 1'b1);
    do_reset();

    // Reset with two ops in flight and two results queued.
    bus.wb_ready = 1'b0;
    for (int t = 1; t <= 4; t++) issue(5'(t + 20));
    idle(1);
    check("midflight_valid", bus.wb_valid,    1'b1);
    check("midflight_ready", bus.issue_ready, 1'b0);
    do_reset();
    check("post_reset_ready", bus.issue_ready, 1'b1);
    check("post_reset_valid", bus.wb_valid,    1'b0);
    bus.wb_ready = 1'b1;
    idle(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_fmul_wb_queue
